// File: rtl/oled_pkg.sv
// Shared constants and types for the ADC-to-BCD formatter and the OLED stage it feeds.
package oled_pkg;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam int BIN_W      = 14;
  localparam logic [BIN_W-1:0] BCD_MAX     = 14'd9999;
  localparam logic [4:0]       BLANK_DIGIT = 5'd16;

  typedef enum logic [2:0] {IDLE, MUL, CLAMP, DD, WAIT, COMMIT} fmtState_t;
endpackage

// File: rtl/adc_bcd_formatter_if.sv
// Sample-in / display-data-out bundle between the ADC wrapper, the formatter and the OLED control.
interface adc_bcd_formatter_if
  import oled_pkg::*;
#(parameter int ADC_BITS = 12);
  logic [ADC_BITS-1:0] iSample;
  logic                iValid;
  logic                iDispBusy;
  logic [BCD_W-1:0]    oBcdData;
  logic                oUpdate;
  logic                oOverflow;
  logic                oBusy;

  modport master (output iSample, iValid, iDispBusy,
                  input  oBcdData, oUpdate, oOverflow, oBusy);
  modport slave  (input  iSample, iValid, iDispBusy,
                  output oBcdData, oUpdate, oOverflow, oBusy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble, one shift per cycle. done is high during the last iteration;
// bcdOut holds the final result from the following cycle until the next start.
module bin2bcd_seq
  import oled_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] binIn,
  output logic [BCD_W-1:0] bcdOut,
  output logic             done
);
  localparam logic [3:0] ITERS = 4'(BIN_W);

  logic [BIN_W-1:0] binReg;
  logic [BCD_W-1:0] bcdReg;
  logic [BCD_W-1:0] adj;
  logic [3:0]       iterCnt;

  always_comb begin
    adj = bcdReg;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcdReg[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcdReg[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      binReg  <= '0;
      bcdReg  <= '0;
      iterCnt <= '0;
    end else if (start) begin
      binReg  <= binIn;
      bcdReg  <= '0;
      iterCnt <= ITERS;
    end else if (iterCnt != 4'd0) begin
      bcdReg  <= {adj[BCD_W-2:0], binReg[BIN_W-1]};
      binReg  <= {binReg[BIN_W-2:0], 1'b0};
      iterCnt <= iterCnt - 4'd1;
    end
  end

  assign bcdOut = bcdReg;
  assign done   = (iterCnt == 4'd1);
endmodule

// File: rtl/adc_bcd_formatter.sv
// Scales raw ADC codes to mV, converts to packed BCD and commits to the OLED bus
// only while the display is idle and no faster than once per UPDATE_MS.
//
// state  | meaning
// IDLE   | waiting for a pending sample and an expired hold timer
// MUL    | code * VREF_MV >> ADC_BITS into mvReg
// CLAMP  | limit to 9999, record overflow, start double-dabble
// DD     | 14 double-dabble iterations in bin2bcd_seq
// WAIT   | result ready, holding while the display is busy
// COMMIT | drive result onto the bus, reload hold timer
module adc_bcd_formatter
  import oled_pkg::*;
#(
  parameter int FCLK      = 10000,
  parameter int UPDATE_MS = 100,
  parameter int ADC_BITS  = 12,
  parameter int VREF_MV   = 2500
)(
  input logic                clk,
  input logic                rst,
  adc_bcd_formatter_if.slave bus
);
  localparam int PROD_W   = ADC_BITS + 14;
  localparam int HOLD_CYC = FCLK * UPDATE_MS;
  localparam int HOLD_W   = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [BIN_W-1:0]  VREF_VAL  = BIN_W'(VREF_MV);

  fmtState_t state, nextState;

  logic [ADC_BITS-1:0] capReg, codeReg;
  logic                pending;
  logic [BIN_W-1:0]    mvReg, binIn;
  logic                ovfReg, clampOvf;
  logic [HOLD_W-1:0]   holdCnt;
  logic [BCD_W-1:0]    bcdOut;
  logic                ddDone;
  logic                launch, ddStart, commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (pending && holdCnt == '0) nextState = MUL;
      MUL:     nextState = CLAMP;
      CLAMP:   nextState = DD;
      DD:      if (ddDone) nextState = WAIT;
      WAIT:    if (!bus.iDispBusy) nextState = COMMIT;
      COMMIT:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    launch    = (state == IDLE) && pending && (holdCnt == '0);
    ddStart   = (state == CLAMP);
    commit    = (state == COMMIT);
    bus.oBusy = (state != IDLE);
  end

  assign clampOvf = (mvReg > BCD_MAX);
  assign binIn    = clampOvf ? BCD_MAX : mvReg;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (ddStart),
    .binIn  (binIn),
    .bcdOut (bcdOut),
    .done   (ddDone)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capReg        <= '0;
      pending       <= 1'b0;
      codeReg       <= '0;
      mvReg         <= '0;
      ovfReg        <= 1'b0;
      holdCnt       <= '0;
      bus.oBcdData  <= '0;
      bus.oUpdate   <= 1'b0;
      bus.oOverflow <= 1'b0;
    end else begin
      // a strobe on the launch cycle wins over the clear, so it stays pending
      if (bus.iValid) begin
        capReg  <= bus.iSample;
        pending <= 1'b1;
      end else if (launch) begin
        pending <= 1'b0;
      end
      if (launch) codeReg <= capReg;
      if (state == MUL) mvReg <= BIN_W'((PROD_W'(codeReg) * PROD_W'(VREF_VAL)) >> ADC_BITS);
      if (ddStart) ovfReg <= clampOvf;
      if (commit)               holdCnt <= HOLD_LOAD;
      else if (holdCnt != '0)   holdCnt <= holdCnt - 1'b1;
      bus.oUpdate <= commit;
      if (commit) begin
        bus.oBcdData  <= bcdOut;
        bus.oOverflow <= ovfReg;
      end
    end
  end
endmodule

// File: tb/tb_adc_bcd_formatter.sv
// Directed bench: two formatters (VREF 2500 and 12000 mV) share one stimulus stream.
module tb_adc_bcd_formatter;
  import oled_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sample = '0;
  logic        valid = 1'b0;
  logic        dispBusy = 1'b0;
  int          checks = 0;
  int          errors = 0;

  adc_bcd_formatter_if #(.ADC_BITS(12)) busA();
  adc_bcd_formatter_if #(.ADC_BITS(12)) busB();

  assign busA.iSample = sample;
  assign busA.iValid = valid;
  assign busA.iDispBusy = dispBusy;
  assign busB.iSample = sample;
  assign busB.iValid = valid;
  assign busB.iDispBusy = dispBusy;

  adc_bcd_formatter #(.FCLK(1), .UPDATE_MS(20), .ADC_BITS(12), .VREF_MV(2500)) dutA (
    .clk (clk), .rst (rst), .bus (busA.slave));
  adc_bcd_formatter #(.FCLK(1), .UPDATE_MS(20), .ADC_BITS(12), .VREF_MV(12000)) dutB (
    .clk (clk), .rst (rst), .bus (busB.slave));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendSample(input logic [11:0] v);
    sample = v;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
  endtask

  task automatic waitUpdate(input int limit, output int cyc, output bit seen);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < limit) begin
      tick(1);
      cyc++;
      seen = (busA.oUpdate === 1'b1);
    end
  endtask

  initial begin
    int  lat;
    bit  seen;
    bit  sawUpd;
    bit  dataMoved;

    // reset held, strobe ignored
    tick(2);
    sendSample(12'd2048);
    tick(2);
    check("rst_dataA", busA.oBcdData, 16'h0000);
    check("rst_updA", busA.oUpdate, 1'b0);
    check("rst_ovfA", busA.oOverflow, 1'b0);
    check("rst_busyA", busA.oBusy, 1'b0);
    check("rst_dataB", busB.oBcdData, 16'h0000);
    rst = 1'b1;
    waitUpdate(5, lat, seen);
    check("rel_noupd", seen, 1'b0);
    check("rel_idle", busA.oBusy, 1'b0);

    // capture cycle + 18 launch-to-update cycles
    sendSample(12'd0);
    waitUpdate(100, lat, seen);
    check("s0_seen", seen, 1'b1);
    check("s0_lat", lat, 19);
    check("s0_data", busA.oBcdData, 16'h0000);
    tick(25);

    sendSample(12'd2048);
    tick(1);
    check("s2048_busy", busA.oBusy, 1'b1);
    waitUpdate(100, lat, seen);
    check("s2048_lat", lat, 18);
    check("s2048_data", busA.oBcdData, 16'h1250);
    tick(1);
    check("s2048_pulse", busA.oUpdate, 1'b0);
    tick(25);

    sendSample(12'd4095);
    waitUpdate(100, lat, seen);
    check("s4095_lat", lat, 19);
    check("s4095_dataA", busA.oBcdData, 16'h2499);
    check("s4095_ovfA", busA.oOverflow, 1'b0);
    check("s4095_dataB", busB.oBcdData, 16'h9999);
    check("s4095_ovfB", busB.oOverflow, 1'b1);
    tick(25);

    sendSample(12'd100);
    waitUpdate(100, lat, seen);
    check("s100_seen", seen, 1'b1);
    check("s100_dataA", busA.oBcdData, 16'h0061);
    check("s100_dataB", busB.oBcdData, 16'h0292);
    check("s100_ovfB", busB.oOverflow, 1'b0);
    tick(25);

    // display busy across the whole conversion
    dispBusy = 1'b1;
    sendSample(12'd2048);
    sawUpd = 1'b0;
    dataMoved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (busA.oUpdate !== 1'b0) sawUpd = 1'b1;
      if (busA.oBcdData !== 16'h0061) dataMoved = 1'b1;
    end
    check("busy_noupd", sawUpd, 1'b0);
    check("busy_hold", dataMoved, 1'b0);
    check("busy_wait", busA.oBusy, 1'b1);
    dispBusy = 1'b0;
    // WAIT sees busy low on the next edge, COMMIT drives the bus on the one after
    waitUpdate(10, lat, seen);
    check("busy_lat", lat, 2);
    check("busy_dataA", busA.oBcdData, 16'h1250);
    check("busy_dataB", busB.oBcdData, 16'h6000);

    // three strobes inside the hold window: only the last converts
    sendSample(12'd1000);
    tick(1);
    sendSample(12'd2000);
    tick(1);
    sendSample(12'd3000);
    waitUpdate(100, lat, seen);
    check("rate_seen", seen, 1'b1);
    check("rate_gap", 5 + lat, 38);
    check("rate_dataA", busA.oBcdData, 16'h1831);
    check("rate_dataB", busB.oBcdData, 16'h8789);
    tick(25);

    // reset during the 7th double-dabble iteration
    sendSample(12'd2048);
    tick(9);
    rst = 1'b0;
    #1;
    check("mid_data", busA.oBcdData, 16'h0000);
    check("mid_upd", busA.oUpdate, 1'b0);
    check("mid_busy", busA.oBusy, 1'b0);
    tick(2);
    rst = 1'b1;
    waitUpdate(30, lat, seen);
    check("mid_noupd", seen, 1'b0);
    check("mid_dataHeld", busA.oBcdData, 16'h0000);

    sendSample(12'd4095);
    waitUpdate(100, lat, seen);
    check("post_lat", lat, 19);
    check("post_data", busA.oBcdData, 16'h2499);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
